uart_baud_cfg_ctrl: RTL and testbench
=====================================

Name: uart_baud_cfg_ctrl

Overview:
Sequences run-time changes of the UART baud divisor and fraction into the baud clock generator, so that a rate change never corrupts a frame in flight. It accepts a one-cycle configuration request and asks the TX/RX engines to quiesce. Once both are idle it waits for a baud tick boundary, loads the new divisor and fraction, and pulses a synchronous restart to the generator. It sits between the APB register block and the baud generator / TX / RX.

Parameters:
BAUD_VAL_FRCTN_EN, 0, 1 = pass the fraction through to the generator; 0 = frac_out forced to 3'b000.
RST_BAUD_VAL, 13'd0, value driven on baud_val_out after reset.
DRAIN_TIMEOUT, 16'd4095, maximum cycles spent in DRAIN plus WAIT_TICK before the request is aborted.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous reset, active-high
cfg_wr  input  1  one-cycle request to apply new configuration
cfg_baud_val  input  13  requested divisor
cfg_frac  input  3  requested fraction
tx_busy  input  1  TX engine has a frame in progress
rx_busy  input  1  RX engine has a frame in progress
baud_tick  input  1  tick from baud generator (x16 enable)
quiesce_req  output  1  tells TX/RX not to start new frames
cfg_busy  output  1  request in progress
cfg_done  output  1  one-cycle pulse, new configuration active
cfg_err  output  1  one-cycle pulse, request rejected or aborted
gen_rst  output  1  one-cycle synchronous restart to baud generator
baud_val_out  output  13  divisor driven to generator
frac_out  output  3  fraction driven to generator

Behaviour:
- One clock: CLK. Reset is asynchronous and active-high: RESET.
- All outputs are registered.
- Reset values: baud_val_out=RST_BAUD_VAL; frac_out, quiesce_req, cfg_busy, cfg_done, cfg_err, gen_rst all 0; FSM in IDLE; pending registers cleared.
- FSM states: IDLE, DRAIN, WAIT_TICK, APPLY, RESTART (2 cycles).
- IDLE:
  - On cfg_wr in cycle c, latch cfg_baud_val/cfg_frac into pending registers and go to DRAIN.
  - From c+1: cfg_busy=1 and quiesce_req=1.
- DRAIN:
  - Waits until tx_busy=0 and rx_busy=0 are sampled in 2 consecutive cycles, then goes to WAIT_TICK.
  - A busy reassertion restarts the 2-cycle qualification.
- WAIT_TICK: when baud_tick=1 is sampled in cycle t, go to APPLY.
- APPLY (cycle t+1):
  - baud_val_out = pending divisor.
  - frac_out = pending fraction (0 if BAUD_VAL_FRCTN_EN=0).
  - gen_rst=1 for exactly this cycle.
- RESTART (t+2, t+3): gen_rst=0, quiesce_req held at 1.
- Return to IDLE at t+4 with cfg_done=1 for one cycle, cfg_busy=0, quiesce_req=0.
- Minimum latency, with engines idle and tick present: cfg_wr at c, gen_rst at c+4, cfg_done at c+7.
- Timeout:
  - A 16-bit timer clears on DRAIN entry and increments each cycle in DRAIN/WAIT_TICK.
  - When it reaches DRAIN_TIMEOUT before APPLY: cfg_err=1 for one cycle, return to IDLE, quiesce_req=0, cfg_busy=0.
  - baud_val_out/frac_out are unchanged and pending is discarded.
- cfg_wr while cfg_busy=1 (any non-IDLE state, including the cycle cfg_done is asserted is NOT busy): request ignored, pending untouched, cfg_err=1 for one cycle.
- Simultaneous timeout and rejected cfg_wr in the same cycle: single cfg_err pulse.
- cfg_wr in the same cycle cfg_done=1: accepted normally, since the FSM is in IDLE.
- Divisor 0 is legal and passed through (tick every cycle). No comparison against the current value; identical values still run the full sequence.
- RESET asserted mid-sequence: immediate return to reset values. No cfg_done or cfg_err is generated; gen_rst is deasserted.
- baud_tick is ignored outside WAIT_TICK. tx_busy/rx_busy are ignored outside DRAIN.

Test Plan:
1. Reset, then cfg_wr with val=13'd26, frac=3'b011 (FRCTN_EN=1), engines idle, tick every 4 cycles -> gen_rst one cycle at the first tick after c+3; baud_val_out=26, frac_out=3 in that cycle; cfg_done 3 cycles later; busy/quiesce low after.
2. FRCTN_EN=0, cfg_wr val=13'd5, frac=3'b111 -> frac_out stays 0, baud_val_out=5, cfg_done asserted.
3. tx_busy held high 50 cycles after cfg_wr, rx_busy toggles once -> no gen_rst until 2 idle cycles, quiesce_req high throughout, then normal apply/done.
4. DRAIN_TIMEOUT=16, rx_busy stuck high -> cfg_err one pulse at timeout; baud_val_out keeps old value; quiesce_req=0; no gen_rst.
5. Second cfg_wr (val=13'd9) while in WAIT_TICK -> cfg_err pulse; first request's value is applied, not 9.
6. RESET asserted during RESTART -> all outputs at reset values immediately (baud_val_out=RST_BAUD_VAL); no cfg_done after release.

Source files
------------

// File: rtl/uart_baud_cfg_ctrl.sv
// Baud divisor/fraction update sequencer: quiesces TX/RX, waits for a tick boundary,
// loads the new configuration and pulses a synchronous restart to the baud generator.
module uart_baud_cfg_ctrl #(
    parameter bit          BAUD_VAL_FRCTN_EN = 1'b0,
    parameter logic [12:0] RST_BAUD_VAL      = 13'd0,
    parameter logic [15:0] DRAIN_TIMEOUT     = 16'd4095
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cfg_wr,
    input  logic [12:0] cfg_baud_val,
    input  logic [2:0]  cfg_frac,
    input  logic        tx_busy,
    input  logic        rx_busy,
    input  logic        baud_tick,
    output logic        quiesce_req,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        gen_rst,
    output logic [12:0] baud_val_out,
    output logic [2:0]  frac_out
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WAIT_TICK,
        APPLY,
        RESTART1,
        RESTART2
    } state_t;

    state_t      state_q;
    logic [12:0] pend_val_q;
    logic [2:0]  pend_frac_q;
    logic [15:0] timer_q;
    logic        idle_seen_q;
    logic        quiesce_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        gen_rst_q;
    logic [12:0] baud_val_q;
    logic [2:0]  frac_q;

    logic [15:0] timer_inc;
    logic        timeout_hit;
    logic        engines_busy;

    assign timer_inc    = timer_q + 16'd1;
    assign timeout_hit  = (timer_inc == DRAIN_TIMEOUT);
    assign engines_busy = tx_busy | rx_busy;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            pend_val_q  <= 13'd0;
            pend_frac_q <= 3'd0;
            timer_q     <= 16'd0;
            idle_seen_q <= 1'b0;
            quiesce_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            gen_rst_q   <= 1'b0;
            baud_val_q  <= RST_BAUD_VAL;
            frac_q      <= 3'd0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            gen_rst_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cfg_wr) begin
                        pend_val_q  <= cfg_baud_val;
                        pend_frac_q <= cfg_frac;
                        timer_q     <= 16'd0;
                        idle_seen_q <= 1'b0;
                        busy_q      <= 1'b1;
                        quiesce_q   <= 1'b1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    timer_q <= timer_inc;
                    if (timeout_hit) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        quiesce_q   <= 1'b0;
                        pend_val_q  <= 13'd0;
                        pend_frac_q <= 3'd0;
                        state_q     <= IDLE;
                    end else if (engines_busy) begin
                        idle_seen_q <= 1'b0;
                    end else if (idle_seen_q) begin
                        state_q <= WAIT_TICK;
                    end else begin
                        idle_seen_q <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    timer_q <= timer_inc;
                    // A tick on the last allowed cycle still wins over the abort.
                    if (baud_tick) begin
                        baud_val_q <= pend_val_q;
                        frac_q     <= BAUD_VAL_FRCTN_EN ? pend_frac_q : 3'd0;
                        gen_rst_q  <= 1'b1;
                        state_q    <= APPLY;
                    end else if (timeout_hit) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        quiesce_q   <= 1'b0;
                        pend_val_q  <= 13'd0;
                        pend_frac_q <= 3'd0;
                        state_q     <= IDLE;
                    end
                end
                APPLY: begin
                    state_q <= RESTART1;
                end
                RESTART1: begin
                    state_q <= RESTART2;
                end
                RESTART2: begin
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    quiesce_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Requests arriving while a sequence is in flight are refused.
            if (cfg_wr && (state_q != IDLE)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign quiesce_req  = quiesce_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign gen_rst      = gen_rst_q;
    assign baud_val_out = baud_val_q;
    assign frac_out     = frac_q;

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Directed bench for uart_baud_cfg_ctrl: three instances cover fraction on/off and a short timeout.
module tb_uart_baud_cfg_ctrl;

    logic        CLK;
    logic        RESET;
    logic        wr_a, wr_b, wr_c;
    logic [12:0] cfg_baud_val;
    logic [2:0]  cfg_frac;
    logic        tx_busy, rx_busy, baud_tick;

    logic        a_q, a_busy, a_done, a_err, a_grst;
    logic [12:0] a_baud;
    logic [2:0]  a_frac;
    logic        b_q, b_busy, b_done, b_err, b_grst;
    logic [12:0] b_baud;
    logic [2:0]  b_frac;
    logic        c_q, c_busy, c_done, c_err, c_grst;
    logic [12:0] c_baud;
    logic [2:0]  c_frac;

    int checks;
    int failures;

    logic [20:0] obs;
    logic [20:0] exp_v;

    uart_baud_cfg_ctrl #(.BAUD_VAL_FRCTN_EN(1'b1), .RST_BAUD_VAL(13'd100), .DRAIN_TIMEOUT(16'd4095)) dut_a (
        .CLK(CLK), .RESET(RESET), .cfg_wr(wr_a), .cfg_baud_val(cfg_baud_val), .cfg_frac(cfg_frac),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .baud_tick(baud_tick),
        .quiesce_req(a_q), .cfg_busy(a_busy), .cfg_done(a_done), .cfg_err(a_err), .gen_rst(a_grst),
        .baud_val_out(a_baud), .frac_out(a_frac));

    uart_baud_cfg_ctrl #(.BAUD_VAL_FRCTN_EN(1'b0), .RST_BAUD_VAL(13'd7), .DRAIN_TIMEOUT(16'd4095)) dut_b (
        .CLK(CLK), .RESET(RESET), .cfg_wr(wr_b), .cfg_baud_val(cfg_baud_val), .cfg_frac(cfg_frac),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .baud_tick(baud_tick),
        .quiesce_req(b_q), .cfg_busy(b_busy), .cfg_done(b_done), .cfg_err(b_err), .gen_rst(b_grst),
        .baud_val_out(b_baud), .frac_out(b_frac));

    uart_baud_cfg_ctrl #(.BAUD_VAL_FRCTN_EN(1'b1), .RST_BAUD_VAL(13'd100), .DRAIN_TIMEOUT(16'd16)) dut_c (
        .CLK(CLK), .RESET(RESET), .cfg_wr(wr_c), .cfg_baud_val(cfg_baud_val), .cfg_frac(cfg_frac),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .baud_tick(baud_tick),
        .quiesce_req(c_q), .cfg_busy(c_busy), .cfg_done(c_done), .cfg_err(c_err), .gen_rst(c_grst),
        .baud_val_out(c_baud), .frac_out(c_frac));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
        exp_v = {5'b00000, 13'd100, 3'd0};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL reset_a got=%h exp=%h", obs, exp_v);
            failures++;
        end
        obs   = {b_grst, b_done, b_err, b_busy, b_q, b_baud, b_frac};
        exp_v = {5'b00000, 13'd7, 3'd0};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL reset_b got=%h exp=%h", obs, exp_v);
            failures++;
        end
        obs   = {c_grst, c_done, c_err, c_busy, c_q, c_baud, c_frac};
        exp_v = {5'b00000, 13'd100, 3'd0};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL reset_c got=%h exp=%h", obs, exp_v);
            failures++;
        end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_basic_apply();
        cfg_baud_val = 13'd26;
        cfg_frac     = 3'b011;
        wr_a         = 1'b1;
        baud_tick    = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            wr_a      = 1'b0;
            baud_tick = ((k % 4) == 2);
            obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
            exp_v = {(k == 7), (k == 10), 1'b0, (k >= 1 && k <= 9), (k >= 1 && k <= 9),
                     (k >= 7) ? 13'd26 : 13'd100, (k >= 7) ? 3'd3 : 3'd0};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL basic_apply k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        baud_tick = 1'b0;
    endtask

    task automatic test_frac_disabled();
        cfg_baud_val = 13'd5;
        cfg_frac     = 3'b111;
        wr_b         = 1'b1;
        baud_tick    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            wr_b  = 1'b0;
            obs   = {b_grst, b_done, b_err, b_busy, b_q, b_baud, b_frac};
            exp_v = {(k == 4), (k == 7), 1'b0, (k <= 6), (k <= 6),
                     (k >= 4) ? 13'd5 : 13'd7, 3'd0};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL frac_disabled k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        baud_tick = 1'b0;
    endtask

    task automatic test_drain_busy();
        cfg_baud_val = 13'd40;
        cfg_frac     = 3'd1;
        wr_a         = 1'b1;
        tx_busy      = 1'b1;
        rx_busy      = 1'b0;
        baud_tick    = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            wr_a    = 1'b0;
            tx_busy = (k <= 50);
            rx_busy = (k == 52);
            obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
            exp_v = {(k == 56), (k == 59), 1'b0, (k <= 58), (k <= 58),
                     (k >= 56) ? 13'd40 : 13'd26, (k >= 56) ? 3'd1 : 3'd3};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL drain_busy k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        tx_busy   = 1'b0;
        rx_busy   = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic test_timeout();
        cfg_baud_val = 13'd77;
        cfg_frac     = 3'd2;
        wr_c         = 1'b1;
        rx_busy      = 1'b1;
        baud_tick    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            wr_c  = 1'b0;
            obs   = {c_grst, c_done, c_err, c_busy, c_q, c_baud, c_frac};
            exp_v = {1'b0, 1'b0, (k == 17), (k <= 16), (k <= 16), 13'd100, 3'd0};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL timeout k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        rx_busy   = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        cfg_baud_val = 13'd60;
        cfg_frac     = 3'd4;
        wr_a         = 1'b1;
        baud_tick    = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            cfg_baud_val = 13'd9;
            cfg_frac     = 3'd5;
            wr_a         = (k == 4) || (k == 10);
            baud_tick    = (k == 6) || (k >= 10);
            obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
            exp_v = {(k == 7) || (k == 14), (k == 10) || (k == 17), (k == 5),
                     (k <= 9) || (k >= 11 && k <= 16), (k <= 9) || (k >= 11 && k <= 16),
                     (k < 7) ? 13'd40 : ((k < 14) ? 13'd60 : 13'd9),
                     (k < 7) ? 3'd1 : ((k < 14) ? 3'd4 : 3'd5)};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL back_to_back k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        wr_a      = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic test_reset_mid_sequence();
        cfg_baud_val = 13'd33;
        cfg_frac     = 3'd6;
        wr_a         = 1'b1;
        baud_tick    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            wr_a = 1'b0;
        end
        obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
        exp_v = {5'b00011, 13'd33, 3'd6};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL restart_state got=%h exp=%h", obs, exp_v);
            failures++;
        end
        RESET = 1'b1;
        #1;
        obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
        exp_v = {5'b00000, 13'd100, 3'd0};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL async_reset_a got=%h exp=%h", obs, exp_v);
            failures++;
        end
        obs   = {b_grst, b_done, b_err, b_busy, b_q, b_baud, b_frac};
        exp_v = {5'b00000, 13'd7, 3'd0};
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL async_reset_b got=%h exp=%h", obs, exp_v);
            failures++;
        end
        step();
        step();
        RESET = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            obs   = {a_grst, a_done, a_err, a_busy, a_q, a_baud, a_frac};
            exp_v = {5'b00000, 13'd100, 3'd0};
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs, exp_v);
                failures++;
            end
        end
        baud_tick = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RESET        = 1'b1;
        wr_a         = 1'b0;
        wr_b         = 1'b0;
        wr_c         = 1'b0;
        cfg_baud_val = 13'd0;
        cfg_frac     = 3'd0;
        tx_busy      = 1'b0;
        rx_busy      = 1'b0;
        baud_tick    = 1'b0;
        test_reset();
        test_basic_apply();
        test_frac_disabled();
        test_drain_busy();
        test_timeout();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
